// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: PC/IR/regfile/ALU/memory strobes,
// unified memory req/ready handshake, retire counter, memory-timeout halt.
module mc_control_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_o,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_HALT   = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam int WCW = $clog2(TIMEOUT + 2);

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  logic       pc_en_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       ir_write_c, reg_dst_c, mem_to_reg_c, reg_write_c;
  logic       alu_src_a_c, ill_c, retire, is_mem;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    pc_en_c      = 1'b0;
    i_or_d_c     = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_source_c  = 2'b00;
    ill_c        = 1'b0;
    retire       = 1'b0;
    is_mem       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        is_mem      = 1'b1;
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        pc_en_c     = mem_ready;
        ir_write_c  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        unique case (1'b1)
          (opcode == OP_R):    state_d = S_EXEC;
          (opcode == OP_LW),
          (opcode == OP_SW):   state_d = S_MEMADR;
          (opcode == OP_BEQ):  state_d = S_BRANCH;
          (opcode == OP_J):    state_d = S_JUMP;
          (opcode == OP_ADDI): state_d = S_ADDIEX;
          default: begin
            ill_c   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        is_mem     = 1'b1;
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        is_mem      = 1'b1;
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_source_c = 2'b01;
        pc_en_c     = zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_source_c = 2'b10;
        pc_en_c     = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // A stall that has already used up its budget abandons the access.
    if (is_mem && !mem_ready) begin
      if (TIMEOUT != 0 && wait_q == WCW'(TIMEOUT)) begin
        state_d = S_HALT;
        tmo_d   = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    if (state_d != state_q) wait_d = '0;
    if (retire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Reset masks the strobes combinationally so no access completes.
  assign pc_en       = pc_en_c & rst_n;
  assign i_or_d      = i_or_d_c & rst_n;
  assign mem_read    = mem_read_c & rst_n;
  assign mem_write   = mem_write_c & rst_n;
  assign ir_write    = ir_write_c & rst_n;
  assign reg_dst     = reg_dst_c & rst_n;
  assign mem_to_reg  = mem_to_reg_c & rst_n;
  assign reg_write   = reg_write_c & rst_n;
  assign alu_src_a   = alu_src_a_c & rst_n;
  assign alu_src_b   = alu_src_b_c & {2{rst_n}};
  assign alu_op      = alu_op_c & {2{rst_n}};
  assign pc_source   = pc_source_c & {2{rst_n}};
  assign illegal_op  = ill_c & rst_n;
  assign state_o     = state_q;
  assign mem_timeout = tmo_q;
  assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level stimulus queues per-cycle
// expectations; a negedge monitor pops and compares.
module tb_mc_control_fsm;

  localparam int TMO = 15;
  localparam int CW  = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [14:0] PCE   = 15'h4000;
  localparam logic [14:0] IOD   = 15'h2000;
  localparam logic [14:0] MRD   = 15'h1000;
  localparam logic [14:0] MWR   = 15'h0800;
  localparam logic [14:0] IRW   = 15'h0400;
  localparam logic [14:0] RDST  = 15'h0200;
  localparam logic [14:0] M2R   = 15'h0100;
  localparam logic [14:0] RW    = 15'h0080;
  localparam logic [14:0] SA    = 15'h0040;
  localparam logic [14:0] SB4   = 15'h0010;
  localparam logic [14:0] SBSE  = 15'h0020;
  localparam logic [14:0] SBSH  = 15'h0030;
  localparam logic [14:0] OPSUB = 15'h0004;
  localparam logic [14:0] OPF   = 15'h0008;
  localparam logic [14:0] PSOUT = 15'h0001;
  localparam logic [14:0] PSJ   = 15'h0002;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    opcode = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic          reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state_o;
  logic          illegal_op, mem_timeout;
  logic [CW-1:0] instr_cnt;

  mc_control_fsm #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_o(state_o), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic [14:0] sig;
    int          cnt;
    bit          tmo;
    bit          ill;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors = 0;
  int   m_cnt = 0;
  bit   m_tmo = 1'b0;
  bit   halted = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic int pick_stalls();
    int r;
    r = int'($urandom % 100);
    if (r < 60) return 0;
    if (r < 90) return 1 + int'($urandom % 4);
    if (r < 96) return TMO;
    return TMO + 1;
  endfunction

  task automatic step(int st, bit rdy, bit z, logic [5:0] op,
                      logic [14:0] sig, bit ill, bit ret);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    e.st = st; e.sig = sig; e.cnt = m_cnt; e.tmo = m_tmo; e.ill = ill;
    q.push_back(e);
    if (ret) m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic rst_cycles(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      mem_ready = rb();
      zero      = rb();
      opcode    = rop();
      m_cnt  = 0;
      m_tmo  = 1'b0;
      halted = 1'b0;
      e.st = 0; e.sig = '0; e.cnt = 0; e.tmo = 1'b0; e.ill = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic mem_acc(int st, logic [14:0] sig, logic [14:0] done_sig,
                         int stalls, bit ret);
    int n;
    n = (stalls > TMO + 1) ? TMO + 1 : stalls;
    for (int k = 0; k < n; k++) step(st, 1'b0, rb(), rop(), sig, 1'b0, 1'b0);
    if (stalls > TMO) begin
      m_tmo  = 1'b1;
      halted = 1'b1;
      return;
    end
    step(st, 1'b1, rb(), rop(), done_sig, 1'b0, ret);
  endtask

  task automatic halt_cycles(int n);
    for (int i = 0; i < n; i++) step(15, rb(), rb(), rop(), '0, 1'b0, 1'b0);
  endtask

  task automatic run_instr(logic [5:0] op, int fs, int ms, bit z);
    bit legal;
    legal = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    mem_acc(0, MRD | SB4, MRD | SB4 | PCE | IRW, fs, 1'b0);
    if (halted) return;
    step(1, rb(), rb(), op, SBSH, !legal, 1'b0);
    case (op)
      OP_LW: begin
        step(2, rb(), rb(), op, SA | SBSE, 1'b0, 1'b0);
        mem_acc(3, IOD | MRD, IOD | MRD, ms, 1'b0);
        if (halted) return;
        step(4, rb(), rb(), rop(), M2R | RW, 1'b0, 1'b1);
      end
      OP_SW: begin
        step(2, rb(), rb(), op, SA | SBSE, 1'b0, 1'b0);
        mem_acc(5, IOD | MWR, IOD | MWR, ms, 1'b1);
      end
      OP_R: begin
        step(6, rb(), rb(), rop(), SA | OPF, 1'b0, 1'b0);
        step(7, rb(), rb(), rop(), RDST | RW, 1'b0, 1'b1);
      end
      OP_BEQ:
        step(8, rb(), z, rop(), SA | OPSUB | PSOUT | (z ? PCE : 15'h0),
             1'b0, 1'b1);
      OP_J:
        step(9, rb(), rb(), rop(), PSJ | PCE, 1'b0, 1'b1);
      OP_ADDI: begin
        step(10, rb(), rb(), rop(), SA | SBSE, 1'b0, 1'b0);
        step(11, rb(), rb(), rop(), RW, 1'b0, 1'b1);
      end
      default: ;
    endcase
  endtask

  function automatic logic [5:0] rand_illegal();
    logic [5:0] op;
    op = rop();
    while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI}) op = rop();
    return op;
  endfunction

  task automatic mid_write_reset();
    exp_t e;
    run_instr(OP_J, 0, 0, 1'b0);
    mem_acc(0, MRD | SB4, MRD | SB4 | PCE | IRW, 0, 1'b0);
    step(1, rb(), rb(), OP_SW, SBSH, 1'b0, 1'b0);
    step(2, rb(), rb(), OP_SW, SA | SBSE, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(5, 1'b0, rb(), rop(), IOD | MWR, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #1;
    chk("pre_reset_mem_write", int'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mem_write", int'(mem_write), 0);
    chk("reset_state", int'(state_o), 0);
    m_cnt = 0;
    m_tmo = 1'b0;
    e.st = 0; e.sig = '0; e.cnt = 0; e.tmo = 1'b0; e.ill = 1'b0;
    q.push_back(e);
    rst_cycles(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [14:0] sig;
    if (q.size() > 0) begin
      e = q.pop_front();
      sig = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
      chk("state", int'(state_o), e.st);
      chk("strobes", int'(sig), int'(e.sig));
      chk("instr_cnt", int'(instr_cnt), e.cnt);
      chk("mem_timeout", int'(mem_timeout), int'(e.tmo));
      chk("illegal_op", int'(illegal_op), int'(e.ill));
    end
  end

  initial begin
    int r;
    rst_cycles(2);
    run_instr(OP_LW, 0, 0, 1'b0);
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_SW, 0, TMO, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OP_ADDI, 2, 0, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    rst_cycles(1);
    for (int i = 0; i < 17; i++) run_instr(OP_J, 0, 0, 1'b0);
    run_instr(OP_LW, 0, TMO + 1, 1'b0);
    halt_cycles(4);
    rst_cycles(1);
    run_instr(OP_J, TMO + 1, 0, 1'b0);
    halt_cycles(4);
    rst_cycles(2);
    mid_write_reset();
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom % 7);
      case (r)
        0: run_instr(OP_LW, pick_stalls(), pick_stalls(), rb());
        1: run_instr(OP_SW, pick_stalls(), pick_stalls(), rb());
        2: run_instr(OP_R, pick_stalls(), 0, rb());
        3: run_instr(OP_BEQ, pick_stalls(), 0, rb());
        4: run_instr(OP_J, pick_stalls(), 0, rb());
        5: run_instr(OP_ADDI, pick_stalls(), 0, rb());
        default: run_instr(rand_illegal(), pick_stalls(), 0, rb());
      endcase
      if (halted) begin
        halt_cycles(3);
        rst_cycles(2);
      end
    end
    repeat (5) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
